// File: rtl/prod_engine_pkg.sv
// ---------------------------------------------------------------------------
// prod_engine_pkg
//   Shared types and constants for the signed 16x16 -> 32 product engine.
//   - state_t       : top-level sequencer states
//   - BYTES_PER_PAIR: bytes per operand pair / per stored product
//   - OP_W, PROD_W  : operand and product widths
//   - mag16()       : two's-complement magnitude of a 16-bit operand
// ---------------------------------------------------------------------------
package prod_engine_pkg;

    typedef enum logic [2:0] {
        LOAD,
        MUL,
        FIX,
        STORE,
        DONE
    } state_t;

    localparam int BYTES_PER_PAIR = 4;
    localparam int OP_W           = 16;
    localparam int PROD_W         = 32;

    // -32768 maps to 16'h8000, which is exactly 32768 when read as unsigned,
    // so 16 unsigned bits are enough for every magnitude.
    function automatic logic [OP_W-1:0] mag16(input logic [OP_W-1:0] x);
        return x[OP_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mul16_seq.sv
// ---------------------------------------------------------------------------
// mul16_seq
//   Sequential unsigned 16x16 -> 32 shift-add multiplier, one partial
//   product per clock.
//   Ports:
//     Clk, Reset : clock (rising edge), synchronous active-high reset
//     start      : load a (multiplicand) and b (multiplier), begin
//     a, b       : unsigned 16-bit operands
//     busy       : iterations in progress
//     done       : high in the cycle whose edge completes the last iteration
//     prod       : 32-bit product, valid after the done edge
//   Build option: PROD_EARLY_TERM_EN ends the run as soon as the remaining
//   multiplier bits are all zero (at least one iteration).
// ---------------------------------------------------------------------------
module mul16_seq
    import prod_engine_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] mcand;
    logic [OP_W-1:0]   mplier;
    logic [3:0]        cnt;
    logic              last;

`ifdef PROD_EARLY_TERM_EN
    // Once the bits still to be shifted in are zero, no further adds happen.
    assign last = (cnt == 4'd15) || (mplier[OP_W-1:1] == '0);
`else
    assign last = (cnt == 4'd15);
`endif

    assign done = busy && last;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= PROD_W'(a);
            mplier <= b;
            prod   <= '0;
        end else if (busy) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (last) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/prod_engine.sv
// ---------------------------------------------------------------------------
// prod_engine
//   Memory-port master that walks PAIRS signed 16-bit operand pairs in
//   byte-wide data memory and writes each exact signed 32-bit product back
//   big-endian. 25 cycles per pair: LOAD 4, MUL 16, FIX 1, STORE 4.
//   Ports:
//     Clk       : clock, rising edge
//     Reset     : synchronous active-high; its falling edge starts a run
//     mem_addr  : byte address to data memory
//     mem_rdata : combinational read data for mem_addr
//     mem_wdata : write byte
//     mem_we    : write enable, memory writes on the Clk edge
//     Done      : all products written, held until Reset
//   Build option: PROD_EARLY_TERM_EN (see mul16_seq) shortens MUL.
// ---------------------------------------------------------------------------
module prod_engine
    import prod_engine_pkg::*;
#(
    parameter int PAIRS    = 16,
    parameter int OP_BASE  = 0,
    parameter int RES_BASE = 64,
    parameter int ADDR_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              Done
);

    localparam int JW = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    state_t            state_q, state_d;
    logic [JW-1:0]     j;
    logic [1:0]        k;
    logic [7:0]        a_hi, a_lo, b_hi;
    logic              sign;
    logic [PROD_W-1:0] res;

    logic              mul_start, mul_busy, mul_done;
    logic [PROD_W-1:0] mul_prod;
    logic [OP_W-1:0]   op_a, op_b;

    // The last operand byte is still on mem_rdata when the core starts, so
    // B is assembled from it directly instead of waiting a cycle for B_lo.
    assign op_a = {a_hi, a_lo};
    assign op_b = {b_hi, mem_rdata};

    mul16_seq u_mul (
        .Clk   (Clk),
        .Reset (Reset),
        .start (mul_start),
        .a     (mag16(op_a)),
        .b     (mag16(op_b)),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            LOAD: begin
                if (k == 2'd3) begin
                    state_d   = MUL;
                    mul_start = 1'b1;
                end
            end
            // An idle core in MUL can only mean it already finished.
            MUL:   if (mul_done || !mul_busy) state_d = FIX;
            FIX:   state_d = STORE;
            STORE: begin
                if (k == 2'd3) state_d = (j == JW'(PAIRS - 1)) ? DONE : LOAD;
            end
            DONE:    state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= LOAD;
            j       <= '0;
            k       <= '0;
            a_hi    <= '0;
            a_lo    <= '0;
            b_hi    <= '0;
            sign    <= 1'b0;
            res     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    case (k)
                        2'd0:    a_hi <= mem_rdata;
                        2'd1:    a_lo <= mem_rdata;
                        2'd2:    b_hi <= mem_rdata;
                        default: sign <= a_hi[7] ^ b_hi[7];
                    endcase
                    k <= k + 2'd1;
                end
                // A zero magnitude product stays zero: no negative zero.
                FIX: res <= (sign && (mul_prod != '0)) ? (~mul_prod + 1'b1) : mul_prod;
                STORE: begin
                    k <= k + 2'd1;
                    if (k == 2'd3 && j != JW'(PAIRS - 1)) j <= j + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory port is decoded from the sequencer state: it shows the reset
    // values (OP_BASE, no write, zero data) whenever the block is in LOAD
    // with j=k=0.
    always_comb begin
        mem_addr  = ADDR_W'(OP_BASE) + ADDR_W'(j) * ADDR_W'(BYTES_PER_PAIR) + ADDR_W'(k);
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_q == STORE) begin
            mem_addr = ADDR_W'(RES_BASE) + ADDR_W'(j) * ADDR_W'(BYTES_PER_PAIR) + ADDR_W'(k);
            mem_we   = 1'b1;
            case (k)
                2'd0:    mem_wdata = res[31:24];
                2'd1:    mem_wdata = res[23:16];
                2'd2:    mem_wdata = res[15:8];
                default: mem_wdata = res[7:0];
            endcase
        end
    end

    assign Done = (state_q == DONE);

endmodule

// File: doc/prod_engine.md
Name: prod_engine

Overview:
- Hardware responder for the program-3 request/done handshake: two's-complement 16x16 -> 32-bit multiply over data memory.
- While Reset is high the block is held. After Reset falls it walks 16 operand pairs in byte-wide data memory, computes each signed product with a sequential shift-add core, and writes it back big-endian.
- Asserts Done when all 16 products are written.
- Sits beside data memory as a memory-port master, in place of the software multiply loop.

Parameters:
- PAIRS, 16, number of operand pairs processed.
- OP_BASE, 0, byte address of the first operand.
- RES_BASE, 64, byte address of the first product.
- ADDR_W, 8, data memory address width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high; also the start request (run begins when it falls).
- mem_addr  out  ADDR_W  byte address to data memory.
- mem_rdata  in  8  combinational read data for mem_addr, same cycle.
- mem_wdata  out  8  write byte.
- mem_we  out  1  write enable; memory writes on the Clk edge when high.
- Done  out  1  all products written; held until Reset.

Behaviour:
- Reset (synchronous, active-high), at any posedge with Reset=1:
  - state<=LOAD, pair index j<=0, byte counter<=0, operand/accumulator regs<=0.
  - Done<=0, mem_we<=0, mem_addr<=OP_BASE, mem_wdata<=0.
  - Applies from every state, including mid-LOAD, mid-MUL or mid-STORE.
  - Bytes already written stay in memory; the run restarts from pair 0 after Reset falls.
- Operands for pair j:
  - A = {m[OP_BASE+4j], m[OP_BASE+4j+1]}
  - B = {m[OP_BASE+4j+2], m[OP_BASE+4j+3]}
  - Both signed 16-bit; high byte is at the lower address.
- Product P = B*A, signed 32-bit, exact. -32768*-32768 = 0x40000000 does not overflow.
- Write-back: P[31:24], P[23:16], P[15:8], P[7:0] go to RES_BASE+4j .. RES_BASE+4j+3.
- LOAD, 4 cycles: mem_addr = OP_BASE+4j+k for k=0..3; mem_rdata captured into A_hi, A_lo, B_hi, B_lo at each edge. mem_we=0.
- MUL, 16 cycles:
  - On entry, compute magnitudes |A| and |B| (17-bit safe) and latch sign = A[15]^B[15].
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the 32-bit accumulator; shift the multiplicand left and the multiplier right.
- FIX, 1 cycle: if sign is set, acc <= -acc. If either operand is 0, the result is 0 regardless of sign.
- STORE, 4 cycles: mem_we=1, mem_addr = RES_BASE+4j+k, mem_wdata = byte k of P (MSB first).
- After STORE: if j == PAIRS-1, go to DONE; else j<=j+1 and go to LOAD.
- Timing: 25 cycles per pair. Done=1 after exactly 400 rising edges with Reset=0 (PAIRS=16, feature off).
- DONE: mem_we=0, Done=1, state holds until Reset.
- Reads and writes never overlap: addresses 0..63 are read only, 64..127 are written only.
- Address arithmetic is modulo 2^ADDR_W; with default parameters no wrap occurs.

Optional Feature:
- Macro PROD_EARLY_TERM_EN.
- Defined: MUL exits to FIX as soon as the remaining multiplier bits are all zero, minimum 1 MUL cycle. Cycle count becomes data-dependent; results and memory image are identical.
- Undefined: fixed 16 MUL cycles and the deterministic 400-cycle run.

Decomposition:
- Package prod_engine_pkg holds:
  - state enum {LOAD, MUL, FIX, STORE, DONE};
  - constants for bytes-per-pair (4), operand width (16) and product width (32).
- Sub-module mul16_seq: sequential unsigned 16x16 shift-add core.
  - Ports: start, a, b, busy, done, prod[31:0].
  - Contains the optional early-termination logic.
- The prod_engine top holds the FSM, address generation, sign handling and byte muxing.

Test Plan:
- Pair 0: m[0..3] = 00 03 00 05, Reset pulse -> m[64..67] = 00 00 00 0F; Done rises at edge 400 (feature off).
- A=-2 (FF FE), B=7 (00 07) -> m[64..67] = FF FF FF F2. Also A=-1, B=-1 -> 00 00 00 01.
- Boundaries:
  - A = B = -32768 (80 00) -> 40 00 00 00.
  - A = 32767, B = -32768 -> C0 00 80 00.
  - A = 0, B = -5 -> 00 00 00 00 (no negative zero).
- Full 16-pair random image (seeded) -> every product matches the signed reference model; m[0..63] unchanged; Done held until Reset.
- Reset asserted at cycle 137 (mid-MUL of pair 5) for 2 cycles, then released -> Done=0 during Reset; full correct image after 400 more cycles.
- With PROD_EARLY_TERM_EN: all multipliers = 1 -> identical image; total cycles = 16*(4+1+1+4) = 160.
